// File: rtl/uart_word_in.sv
// 8N1 UART receiver that packs WORD_BYTES bytes (LSB first) into one word and
// presents it on a valid/ready port, with framing, overflow and inter-byte timeout flags.
module uart_word_in #(
    parameter int INPUT_CLOCK_FREQ = 240_000_000,
    parameter int BAUD_RATE        = 250_000,
    parameter int WORD_BYTES       = 8,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    framing_error,
    output logic                    overflow,
    output logic                    sync_lost
);
    localparam int CPB      = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(CPB);
    localparam int W        = 8 * WORD_BYTES;
    localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam int IW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CPB - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TO_END   = TW'(TO_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          rxd_s1_q, rxd_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [W-1:0]  word_q, word_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          sl_q, sl_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_done;
    logic [W-1:0]  full_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxd_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            default: begin
                // Leave mid stop bit so the next start edge is never missed
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    byte_done = rxd_s_q;
                    fe_d      = !rxd_s_q;
                    state_d   = S_IDLE;
                end
            end
        endcase

        idx_d     = idx_q;
        buf_d     = buf_q;
        word_d    = word_q;
        valid_d   = valid_q;
        ov_d      = 1'b0;
        sl_d      = 1'b0;
        full_word = buf_q;
        full_word[int'(idx_q)*8 +: 8] = shift_q;

        if (valid_q && word_ready) valid_d = 1'b0;
        if (byte_done) begin
            buf_d = full_word;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (!valid_q || word_ready) begin
                    word_d  = full_word;
                    valid_d = 1'b1;
                end else begin
                    ov_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (fe_d) idx_d = '0;

        if (byte_done || idx_q == '0) begin
            to_d = '0;
        end else if (to_q == TO_END) begin
            sl_d  = 1'b1;
            idx_d = '0;
            to_d  = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1_q <= 1'b1;
            rxd_s_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            buf_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            sl_q     <= 1'b0;
            to_q     <= '0;
        end else begin
            rxd_s1_q <= uart_rxd;
            rxd_s_q  <= rxd_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            sl_q     <= sl_d;
            to_q     <= to_d;
        end
    end

    assign word_out      = word_q;
    assign word_valid    = valid_q;
    assign framing_error = fe_q;
    assign overflow      = ov_q;
    assign sync_lost     = sl_q;
endmodule

// File: tb/tb_uart_word_in.sv
// Bench for uart_word_in at a reduced bit period (16 clk per bit) so whole words fit a short run.
module tb_uart_word_in;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        word_ready = 1'b0;
    logic [63:0] word_out;
    logic        word_valid, framing_error, overflow, sync_lost;

    int checks = 0;
    int failures = 0;
    int n_fe = 0, n_ov = 0, n_sl = 0, n_acc = 0;
    logic [63:0] acc_mem [0:255];

    always #5 clk = ~clk;

    uart_word_in #(
        .INPUT_CLOCK_FREQ(4_000_000),
        .BAUD_RATE(250_000),
        .WORD_BYTES(8),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rxd(uart_rxd),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .framing_error(framing_error),
        .overflow(overflow),
        .sync_lost(sync_lost)
    );

    // Event monitor: counts pulse cycles and records every accepted word
    always @(negedge clk) begin
        if (framing_error) n_fe <= n_fe + 1;
        if (overflow) n_ov <= n_ov + 1;
        if (sync_lost) n_sl <= n_sl + 1;
        if (word_valid && word_ready) begin
            acc_mem[n_acc[7:0]] <= word_out;
            n_acc <= n_acc + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cyc(CPB);
        end
        uart_rxd = stop_bit;
        cyc(CPB);
        uart_rxd = 1'b1;
        cyc(CPB);
    endtask

    // Reference model: word = sum of byte k shifted left by 8k
    task automatic send_rand_word(output logic [63:0] exp);
        logic [7:0] b;
        exp = '0;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            exp = exp | (64'(b) << (8 * k));
            send_byte(b, 1'b1);
        end
    endtask

    task automatic test_reset;
        cyc(3);
        checks++;
        if ({word_out, word_valid, framing_error, overflow, sync_lost} !== 68'd0) begin
            failures++;
            $display("FAIL reset_outputs got word=%h v=%b fe=%b ov=%b sl=%b want all 0",
                     word_out, word_valid, framing_error, overflow, sync_lost);
        end
        rst = 1'b0;
        cyc(4);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid got %b want 0", word_valid);
        end
    endtask

    task automatic test_basic;
        logic [7:0] seq [8];
        int a0;
        seq = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        word_ready = 1'b1;
        a0 = n_acc;
        for (int k = 0; k < 8; k++) send_byte(seq[k], 1'b1);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1) begin
            failures++;
            $display("FAIL basic_count got %0d words want 1", n_acc - a0);
        end
        checks++;
        if (acc_mem[a0[7:0]] !== 64'h0123456789ABCDEF) begin
            failures++;
            $display("FAIL basic_word got %h want 0123456789abcdef", acc_mem[a0[7:0]]);
        end
    endtask

    task automatic test_glitch;
        int a0, f0, o0, s0;
        logic [63:0] exp;
        a0 = n_acc; f0 = n_fe; o0 = n_ov; s0 = n_sl;
        uart_rxd = 1'b0;
        cyc(5);
        uart_rxd = 1'b1;
        cyc(3 * CPB);
        checks++;
        if ((n_acc - a0) + (n_fe - f0) + (n_ov - o0) + (n_sl - s0) !== 0 || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_quiet got words=%0d fe=%0d ov=%0d sl=%0d v=%b want none",
                     n_acc - a0, n_fe - f0, n_ov - o0, n_sl - s0, word_valid);
        end
        send_rand_word(exp);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1 || acc_mem[a0[7:0]] !== exp) begin
            failures++;
            $display("FAIL glitch_then_word got n=%0d w=%h want n=1 w=%h",
                     n_acc - a0, acc_mem[a0[7:0]], exp);
        end
    endtask

    task automatic test_framing;
        int a0, f0;
        a0 = n_acc; f0 = n_fe;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        cyc(CPB);
        checks++;
        if (n_fe - f0 !== 1) begin
            failures++;
            $display("FAIL framing_pulse got %0d cycles want 1", n_fe - f0);
        end
        for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b1);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1 || acc_mem[a0[7:0]] !== 64'h0807060504030201) begin
            failures++;
            $display("FAIL framing_realign got n=%0d w=%h want n=1 w=0807060504030201",
                     n_acc - a0, acc_mem[a0[7:0]]);
        end
        checks++;
        if (n_fe - f0 !== 1) begin
            failures++;
            $display("FAIL framing_no_extra got %0d want 1", n_fe - f0);
        end
    endtask

    task automatic test_timeout;
        int a0, s0;
        logic [63:0] exp;
        a0 = n_acc; s0 = n_sl;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
        cyc(18 * CPB);
        checks++;
        if (n_sl - s0 !== 0) begin
            failures++;
            $display("FAIL timeout_early got %0d want 0", n_sl - s0);
        end
        cyc(4 * CPB);
        checks++;
        if (n_sl - s0 !== 1) begin
            failures++;
            $display("FAIL timeout_pulse got %0d want 1", n_sl - s0);
        end
        send_rand_word(exp);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1 || acc_mem[a0[7:0]] !== exp) begin
            failures++;
            $display("FAIL timeout_realign got n=%0d w=%h want n=1 w=%h",
                     n_acc - a0, acc_mem[a0[7:0]], exp);
        end
    endtask

    task automatic test_overflow;
        int a0, o0;
        logic [63:0] wa, wb;
        a0 = n_acc; o0 = n_ov;
        word_ready = 1'b0;
        send_rand_word(wa);
        checks++;
        if (word_valid !== 1'b1 || word_out !== wa) begin
            failures++;
            $display("FAIL overflow_hold_a got v=%b w=%h want v=1 w=%h", word_valid, word_out, wa);
        end
        send_rand_word(wb);
        checks++;
        if (n_ov - o0 !== 1) begin
            failures++;
            $display("FAIL overflow_pulse got %0d want 1", n_ov - o0);
        end
        checks++;
        if (word_valid !== 1'b1 || word_out !== wa) begin
            failures++;
            $display("FAIL overflow_keep_a got v=%b w=%h want v=1 w=%h", word_valid, word_out, wa);
        end
        word_ready = 1'b1;
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1 || acc_mem[a0[7:0]] !== wa || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL overflow_consume got n=%0d w=%h v=%b want n=1 w=%h v=0",
                     n_acc - a0, acc_mem[a0[7:0]], word_valid, wa);
        end
    endtask

    task automatic test_reset_mid;
        int a0;
        logic [63:0] wa, wc;
        word_ready = 1'b0;
        send_rand_word(wa);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
        uart_rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = 1'($urandom);
            cyc(CPB);
        end
        rst = 1'b1;
        cyc(2);
        checks++;
        if ({word_out, word_valid, framing_error, overflow, sync_lost} !== 68'd0) begin
            failures++;
            $display("FAIL midreset_outputs got word=%h v=%b fe=%b ov=%b sl=%b want all 0 (held %h)",
                     word_out, word_valid, framing_error, overflow, sync_lost, wa);
        end
        uart_rxd = 1'b1;
        word_ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2 * CPB);
        a0 = n_acc;
        send_rand_word(wc);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 1 || acc_mem[a0[7:0]] !== wc) begin
            failures++;
            $display("FAIL midreset_word got n=%0d w=%h want n=1 w=%h", n_acc - a0, acc_mem[a0[7:0]], wc);
        end
    endtask

    task automatic test_back_to_back;
        int a0;
        logic [63:0] exp [4];
        word_ready = 1'b1;
        a0 = n_acc;
        for (int j = 0; j < 4; j++) send_rand_word(exp[j]);
        cyc(2);
        checks++;
        if (n_acc - a0 !== 4) begin
            failures++;
            $display("FAIL b2b_count got %0d want 4", n_acc - a0);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (acc_mem[8'(a0 + j)] !== exp[j]) begin
                failures++;
                $display("FAIL b2b_word%0d got %h want %h", j, acc_mem[8'(a0 + j)], exp[j]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_framing;
        test_timeout;
        test_overflow;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
